fetch_decode_register: RTL and testbench

IF/ID pipeline register between the fetch stage and the decode stage. It latches the fetched 16-bit instruction, the incremented PC and the interrupt flag, and supports stall and flush. It also assembles two-word LDM instructions (opcode `5'b10010`) into one decode-visible instruction plus a 16-bit immediate, inserting one bubble while the immediate word is fetched.

---
 rtl/fetch_decode_register.sv | 195 +++++++++++++++++++
 tb/tb_fetch_decode_register.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_register.sv
// ---------------------------------------------------------------------------
// fetch_decode_register
//
// IF/ID pipeline register. Latches the fetched 16-bit instruction, its PC+1,
// the interrupt flag and the control-hazard flag. It supports stall and flush.
// A two-word LDM (opcode LDM_OPCODE in bits [15:11]) is merged into one
// decode-visible instruction plus a 16-bit immediate. One bubble is emitted
// while the immediate word is being fetched.
//
// Optional feature macro: FD_BUBBLE_COUNTER_EN
//   When this macro is defined, the module has an extra output o_bubble_count.
//   It is a saturating 16-bit count of the edges on which a bubble is loaded.
//
// Ports
//   i_clk                 clock (rising edge)
//   i_reset               asynchronous active-high reset
//   i_enable              1 = advance, 0 = stall (everything held)
//   i_flush               squash contents; takes priority over i_enable
//   i_instr[15:0]         instruction word from fetch (NOP = 0)
//   i_pc_inc[31:0]        PC+1 from fetch
//   i_interrupt           interrupt flag from fetch
//   i_hazard_instruction  control-hazard flag from fetch
//   o_instr[15:0]         instruction presented to decode
//   o_imm[15:0]           LDM immediate, otherwise 0
//   o_pc_inc[31:0]        PC+1 associated with o_instr
//   o_interrupt           registered interrupt flag
//   o_hazard_instruction  registered hazard flag
//   o_valid               o_instr is a real instruction (not a bubble)
//   o_waiting_imm         FSM state: 1 while waiting for the LDM immediate
//   o_bubble_count[15:0]  bubble counter (FD_BUBBLE_COUNTER_EN only)
//
// Handshake: there is no valid/ready back-pressure. i_enable is the only
// flow control. When i_enable is 1 the register takes i_instr on the edge.
// o_valid qualifies o_instr on every cycle.
// ---------------------------------------------------------------------------
module fetch_decode_register #(
  parameter logic [4:0] LDM_OPCODE = 5'b10010
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_flush,
  input  logic [15:0] i_instr,
  input  logic [31:0] i_pc_inc,
  input  logic        i_interrupt,
  input  logic        i_hazard_instruction,
  output logic [15:0] o_instr,
  output logic [15:0] o_imm,
  output logic [31:0] o_pc_inc,
  output logic        o_interrupt,
  output logic        o_hazard_instruction,
  output logic        o_valid,
  output logic        o_waiting_imm
`ifdef FD_BUBBLE_COUNTER_EN
  ,
  output logic [15:0] o_bubble_count
`endif
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_IMM  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] imm_q, imm_d;
  logic [31:0] pc_q, pc_d;
  logic        int_q, int_d;
  logic        haz_q, haz_d;
  logic        valid_q, valid_d;
  logic [15:0] held_instr_q, held_instr_d;
  logic        held_int_q, held_int_d;
  logic        bubble_load;

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    imm_d        = imm_q;
    pc_d         = pc_q;
    int_d        = int_q;
    haz_d        = haz_q;
    valid_d      = valid_q;
    held_instr_d = held_instr_q;
    held_int_d   = held_int_q;
    bubble_load  = 1'b0;

    if (i_flush) begin
      // A flush in S_IMM drops the held LDM word.
      state_d      = S_IDLE;
      instr_d      = 16'h0000;
      imm_d        = 16'h0000;
      pc_d         = i_pc_inc;
      int_d        = i_interrupt;
      haz_d        = 1'b0;
      valid_d      = 1'b0;
      held_instr_d = 16'h0000;
      held_int_d   = 1'b0;
      bubble_load  = 1'b1;
    end else if (i_enable) begin
      case (state_q)
        S_IDLE: begin
          if (i_instr[15:11] == LDM_OPCODE) begin
            // First LDM word. Park it and emit a bubble. The interrupt flag
            // is held back so that it leaves together with the merged instruction.
            held_instr_d = i_instr;
            held_int_d   = i_interrupt;
            instr_d      = 16'h0000;
            imm_d        = 16'h0000;
            pc_d         = i_pc_inc;
            int_d        = 1'b0;
            haz_d        = 1'b0;
            valid_d      = 1'b0;
            state_d      = S_IMM;
            bubble_load  = 1'b1;
          end else begin
            instr_d = i_instr;
            imm_d   = 16'h0000;
            pc_d    = i_pc_inc;
            int_d   = i_interrupt;
            haz_d   = i_hazard_instruction;
            valid_d = 1'b1;
          end
        end
        S_IMM: begin
          // The incoming word is raw immediate data. It is never decoded,
          // even when it looks like another LDM.
          instr_d      = held_instr_q;
          imm_d        = i_instr;
          pc_d         = i_pc_inc;
          int_d        = held_int_q | i_interrupt;
          haz_d        = 1'b1;
          valid_d      = 1'b1;
          held_instr_d = 16'h0000;
          held_int_d   = 1'b0;
          state_d      = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      instr_q      <= 16'h0000;
      imm_q        <= 16'h0000;
      pc_q         <= 32'h0000_0000;
      int_q        <= 1'b0;
      haz_q        <= 1'b0;
      valid_q      <= 1'b0;
      held_instr_q <= 16'h0000;
      held_int_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      imm_q        <= imm_d;
      pc_q         <= pc_d;
      int_q        <= int_d;
      haz_q        <= haz_d;
      valid_q      <= valid_d;
      held_instr_q <= held_instr_d;
      held_int_q   <= held_int_d;
    end
  end

  assign o_instr              = instr_q;
  assign o_imm                = imm_q;
  assign o_pc_inc             = pc_q;
  assign o_interrupt          = int_q;
  assign o_hazard_instruction = haz_q;
  assign o_valid              = valid_q;
  assign o_waiting_imm        = (state_q == S_IMM);

`ifdef FD_BUBBLE_COUNTER_EN
  logic [15:0] bcnt_q, bcnt_d;

  // Saturating count. A stall never asserts bubble_load, so the count holds.
  always_comb begin
    bcnt_d = bcnt_q;
    if (bubble_load && (bcnt_q != 16'hFFFF)) bcnt_d = bcnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) bcnt_q <= 16'h0000;
    else         bcnt_q <= bcnt_d;
  end

  assign o_bubble_count = bcnt_q;
`else
  logic unused_bubble_load;
  assign unused_bubble_load = bubble_load;
`endif

endmodule

// File: tb/tb_fetch_decode_register.sv
// Bench for fetch_decode_register. The driver applies directed vectors on the
// falling edge and pushes the hand-computed output vector for the next rising
// edge into exp_q. A separate monitor pops one entry after each rising edge
// and compares it with the DUT outputs.
// Expected vector layout: {instr[15:0], imm[15:0], pc_inc[31:0], interrupt,
// hazard, valid, waiting_imm}.
module tb_fetch_decode_register;

  localparam int W = 68;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic        i_flush;
  logic [15:0] i_instr;
  logic [31:0] i_pc_inc;
  logic        i_interrupt;
  logic        i_hazard_instruction;
  logic [15:0] o_instr;
  logic [15:0] o_imm;
  logic [31:0] o_pc_inc;
  logic        o_interrupt;
  logic        o_hazard_instruction;
  logic        o_valid;
  logic        o_waiting_imm;
`ifdef FD_BUBBLE_COUNTER_EN
  logic [15:0] o_bubble_count;
`endif

  logic [W-1:0] exp_q[$];
  int           id_q[$];
  int           checks = 0;
  int           failures = 0;
  int           step_id = 0;

  fetch_decode_register dut (
    .i_clk                (i_clk),
    .i_reset              (i_reset),
    .i_enable             (i_enable),
    .i_flush              (i_flush),
    .i_instr              (i_instr),
    .i_pc_inc             (i_pc_inc),
    .i_interrupt          (i_interrupt),
    .i_hazard_instruction (i_hazard_instruction),
    .o_instr              (o_instr),
    .o_imm                (o_imm),
    .o_pc_inc             (o_pc_inc),
    .o_interrupt          (o_interrupt),
    .o_hazard_instruction (o_hazard_instruction),
    .o_valid              (o_valid),
    .o_waiting_imm        (o_waiting_imm)
`ifdef FD_BUBBLE_COUNTER_EN
    ,
    .o_bubble_count       (o_bubble_count)
`endif
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  function automatic logic [W-1:0] pack(input logic [15:0] ins, input logic [15:0] imm,
                                        input logic [31:0] pc, input logic intr,
                                        input logic haz, input logic vld, input logic wt);
    return {ins, imm, pc, intr, haz, vld, wt};
  endfunction

  function automatic logic [W-1:0] actual();
    return {o_instr, o_imm, o_pc_inc, o_interrupt, o_hazard_instruction, o_valid, o_waiting_imm};
  endfunction

  task automatic check_vec(input string name, input int id, input logic [W-1:0] act,
                           input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got instr=%h imm=%h pc=%h int=%b haz=%b vld=%b wait=%b expected instr=%h imm=%h pc=%h int=%b haz=%b vld=%b wait=%b",
               name, id, act[67:52], act[51:36], act[35:4], act[3], act[2], act[1], act[0],
               exp[67:52], exp[51:36], exp[35:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check_cnt(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // driver: one vector per cycle, applied on the falling edge
  task automatic cyc(input logic en, input logic fl, input logic [15:0] ins,
                     input logic [31:0] pc, input logic intr, input logic haz,
                     input logic [W-1:0] exp);
    @(negedge i_clk);
    i_enable             = en;
    i_flush              = fl;
    i_instr              = ins;
    i_pc_inc             = pc;
    i_interrupt          = intr;
    i_hazard_instruction = haz;
    step_id++;
    exp_q.push_back(exp);
    id_q.push_back(step_id);
  endtask

  // monitor / scoreboard
  initial begin
    logic [W-1:0] e;
    int           id;
    forever begin
      @(posedge i_clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        id = id_q.pop_front();
        check_vec("out", id, actual(), e);
      end
    end
  end

  initial begin
    int waited;
    i_reset = 1'b1; i_enable = 1'b0; i_flush = 1'b0; i_instr = 16'h0;
    i_pc_inc = 32'h0; i_interrupt = 1'b0; i_hazard_instruction = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    check_vec("reset_state", 0, actual(), '0);
`ifdef FD_BUBBLE_COUNTER_EN
    check_cnt("reset_count", o_bubble_count, 16'h0000);
`endif

    // Reset asserted mid-cycle while o_instr=1234
    cyc(1, 0, 16'h1234, 32'h5, 0, 0, pack(16'h1234, 16'h0, 32'h5, 0, 0, 1, 0));
    @(negedge i_clk);
    i_enable = 1'b0;
    #2 i_reset = 1'b1;
    #1 check_vec("async_reset", 0, actual(), '0);
    #1 i_reset = 1'b0;

    // pass-through
    cyc(1, 0, 16'h0801, 32'h10, 0, 0, pack(16'h0801, 16'h0, 32'h10, 0, 0, 1, 0));
    cyc(1, 0, 16'h4123, 32'h11, 1, 1, pack(16'h4123, 16'h0, 32'h11, 1, 1, 1, 0));
    // LDM merge, with the interrupt raised on the first word
    cyc(1, 0, 16'h9200, 32'h20, 1, 0, pack(16'h0, 16'h0, 32'h20, 0, 0, 0, 1));
    cyc(1, 0, 16'hBEEF, 32'h21, 0, 0, pack(16'h9200, 16'hBEEF, 32'h21, 1, 1, 1, 0));
    // stall in S_IMM for 3 cycles
    cyc(1, 0, 16'h9201, 32'h30, 0, 0, pack(16'h0, 16'h0, 32'h30, 0, 0, 0, 1));
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 16'h5555, 32'h99, 1, 1, pack(16'h0, 16'h0, 32'h30, 0, 0, 0, 1));
    cyc(1, 0, 16'h1234, 32'h31, 0, 0, pack(16'h9201, 16'h1234, 32'h31, 0, 1, 1, 0));
    // stall in S_IDLE
    cyc(0, 0, 16'h2222, 32'h77, 1, 0, pack(16'h9201, 16'h1234, 32'h31, 0, 1, 1, 0));
    // flush with enable low while in S_IMM; the held LDM must never appear
    cyc(1, 0, 16'h9300, 32'h40, 0, 0, pack(16'h0, 16'h0, 32'h40, 0, 0, 0, 1));
    cyc(0, 1, 16'h7777, 32'h41, 1, 1, pack(16'h0, 16'h0, 32'h41, 1, 0, 0, 0));
    cyc(1, 0, 16'h0802, 32'h42, 0, 0, pack(16'h0802, 16'h0, 32'h42, 0, 0, 1, 0));
    // immediate word that looks like an LDM is only data
    cyc(1, 0, 16'h9400, 32'h50, 0, 0, pack(16'h0, 16'h0, 32'h50, 0, 0, 0, 1));
    cyc(1, 0, 16'h9000, 32'h51, 0, 1, pack(16'h9400, 16'h9000, 32'h51, 0, 1, 1, 0));
    cyc(1, 0, 16'h0003, 32'h52, 0, 0, pack(16'h0003, 16'h0, 32'h52, 0, 0, 1, 0));
    // flush in S_IDLE, then a NOP
    cyc(1, 1, 16'hAAAA, 32'h60, 0, 0, pack(16'h0, 16'h0, 32'h60, 0, 0, 0, 0));
    cyc(1, 0, 16'h0000, 32'h61, 0, 0, pack(16'h0, 16'h0, 32'h61, 0, 0, 1, 0));
    cyc(0, 0, 16'h9999, 32'h62, 0, 0, pack(16'h0, 16'h0, 32'h61, 0, 0, 1, 0));

`ifdef FD_BUBBLE_COUNTER_EN
    // 2 flushes and 4 first LDM words so far; the stall cycle holds the count
    @(negedge i_clk);
    check_cnt("count_mixed", o_bubble_count, 16'd6);
    for (int i = 0; i < 65529; i++)
      cyc(0, 1, 16'h1111, 32'(1000 + i), 0, 0, pack(16'h0, 16'h0, 32'(1000 + i), 0, 0, 0, 0));
    @(negedge i_clk);
    check_cnt("count_reach_max", o_bubble_count, 16'hFFFF);
    repeat (3) @(negedge i_clk);
    check_cnt("count_saturated", o_bubble_count, 16'hFFFF);
`endif

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge i_clk);
      waited++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
